// File: rtl/mmu_tlb.sv
// mmu_tlb: fully-associative Sv32 TLB (4 KiB pages) that walks through mmu_ptw on a miss.
// Optional build macro MMU_TLB_ASID_EN: ASID-tagged entries with global pages instead of invalidate-on-satp-change.
module mmu_tlb #(
  parameter int ENTRIES   = 8,
  parameter int ENTRIES_W = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] satp_i,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_addr_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  output logic        resp_fault_o,
  output logic [31:0] resp_paddr_o,
  output logic [9:0]  resp_flags_o,
  output logic        busy_o,
  output logic        ptw_req_valid_o,
  output logic [31:0] ptw_req_addr_o,
  input  logic        ptw_update_i,
  input  logic [31:0] ptw_vpn_i,
  input  logic [31:0] ptw_pte_i,
  input  logic        ptw_fault_i,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a lookup is taken on any cycle with lookup_valid_i=1 and busy_o=0; the walk request
  // is a single-cycle pulse with no ready; ptw_update_i is consumed only while waiting for a walk.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_REPLAY = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ENTRIES-1:0]   valid_q;
  logic [19:0]          vpn_q   [ENTRIES];
  logic [19:0]          ppn_q   [ENTRIES];
  logic [9:0]           flags_q [ENTRIES];
  logic [ENTRIES_W-1:0] ptr_q;
  logic [31:0]          vaddr_q;
  logic                 drop_q;

  logic                 mode;
  logic                 inval;
  logic                 lookup;
  logic                 walk_done;
  logic                 fill;
  logic                 hit;
  logic [ENTRIES_W-1:0] hit_idx;
  logic [ENTRIES-1:0]   match;
  logic [13:0]          unused_ptw;

  assign mode       = satp_i[31];
  assign unused_ptw = {ptw_vpn_i[31:20], ptw_pte_i[31:30]};

`ifdef MMU_TLB_ASID_EN
  logic [8:0]  asid_q [ENTRIES];
  logic [21:0] unused_satp;
  assign unused_satp = satp_i[21:0];
  assign inval       = flush_i;
`else
  // Without ASID tags any satp write may change the address space, so it acts as a flush.
  logic [31:0] satp_q;
  assign inval = flush_i | (satp_i != satp_q);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) satp_q <= '0;
    else        satp_q <= satp_i;
  end
`endif

  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = valid_q[i] && (vpn_q[i] == lookup_addr_i[31:12]);
`ifdef MMU_TLB_ASID_EN
      match[i] = match[i] && ((asid_q[i] == satp_i[30:22]) || flags_q[i][5]);
`endif
    end
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = ENTRIES_W'(i);
      end
    end
  end

  assign lookup    = (state_q == S_IDLE) && lookup_valid_i;
  assign walk_done = (state_q == S_WAIT) && mode && ptw_update_i;
  assign fill      = walk_done && !ptw_fault_i && !drop_q && !inval;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (lookup && mode && (inval || !hit)) state_d = S_REQ;
      S_REQ:    state_d = mode ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!mode)             state_d = S_IDLE;
        else if (ptw_update_i) state_d = ptw_fault_i ? S_IDLE : S_REPLAY;
      end
      S_REPLAY: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy_o          = (state_q != S_IDLE);
  assign ptw_req_valid_o = (state_q == S_REQ);
  assign ptw_req_addr_o  = vaddr_q;
  assign dbg_state_o     = state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      vaddr_q      <= '0;
      drop_q       <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_fault_o <= 1'b0;
      resp_paddr_o <= '0;
      resp_flags_o <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_o <= 1'b0;
      resp_fault_o <= 1'b0;
      if (lookup) vaddr_q <= lookup_addr_i;
      if (state_q == S_IDLE) drop_q <= 1'b0;
      else if (inval)        drop_q <= 1'b1;
      if (lookup && !mode) begin
        resp_valid_o <= 1'b1;
        resp_paddr_o <= lookup_addr_i;
        resp_flags_o <= '0;
      end else if (lookup && hit && !inval) begin
        resp_valid_o <= 1'b1;
        resp_paddr_o <= {ppn_q[hit_idx], lookup_addr_i[11:0]};
        resp_flags_o <= flags_q[hit_idx];
      end else if (walk_done) begin
        // The walk result is answered even when the fill was dropped by a flush.
        resp_valid_o <= 1'b1;
        if (ptw_fault_i) begin
          resp_fault_o <= 1'b1;
        end else begin
          resp_paddr_o <= {ptw_pte_i[29:10], vaddr_q[11:0]};
          resp_flags_o <= ptw_pte_i[9:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        vpn_q[i]   <= '0;
        ppn_q[i]   <= '0;
        flags_q[i] <= '0;
`ifdef MMU_TLB_ASID_EN
        asid_q[i]  <= '0;
`endif
      end
    end else begin
      if (inval)     valid_q        <= '0;
      else if (fill) valid_q[ptr_q] <= 1'b1;
      if (fill) begin
        vpn_q[ptr_q]   <= ptw_vpn_i[19:0];
        ppn_q[ptr_q]   <= ptw_pte_i[29:10];
        flags_q[ptr_q] <= ptw_pte_i[9:0];
`ifdef MMU_TLB_ASID_EN
        asid_q[ptr_q]  <= satp_i[30:22];
`endif
        ptr_q <= ptr_q + ENTRIES_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed vector table, hand sequences for flush/abort corners and a randomized run
// checked against an array-based TLB model with a modelled page table.
module tb_mmu_tlb;
  localparam int ENTRIES = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] satp = '0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_addr = '0;
  logic        flush = 1'b0;
  logic        resp_valid, resp_fault, busy, ptw_req_valid;
  logic [31:0] resp_paddr, ptw_req_addr;
  logic [9:0]  resp_flags;
  logic        ptw_update = 1'b0;
  logic [31:0] ptw_vpn = '0;
  logic [31:0] ptw_pte = '0;
  logic        ptw_fault = 1'b0;
  logic [1:0]  dbg_state;

  mmu_tlb #(.ENTRIES(ENTRIES), .ENTRIES_W(3)) dut (
    .clk_i(clk), .rst_i(rst), .satp_i(satp),
    .lookup_valid_i(lookup_valid), .lookup_addr_i(lookup_addr), .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_fault_o(resp_fault), .resp_paddr_o(resp_paddr),
    .resp_flags_o(resp_flags), .busy_o(busy),
    .ptw_req_valid_o(ptw_req_valid), .ptw_req_addr_o(ptw_req_addr),
    .ptw_update_i(ptw_update), .ptw_vpn_i(ptw_vpn), .ptw_pte_i(ptw_pte),
    .ptw_fault_i(ptw_fault), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: slot array filled round-robin by walk count, searched lowest index first.
  logic        m_v    [ENTRIES];
  logic [19:0] m_vpn  [ENTRIES];
  logic [19:0] m_ppn  [ENTRIES];
  logic [9:0]  m_fl   [ENTRIES];
  logic [8:0]  m_asid [ENTRIES];
  int          m_fills = 0;
  logic [42:0] exp_q[$];

  function automatic void m_flush();
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
  endfunction

  function automatic logic m_match(int i, logic [19:0] vpn);
`ifdef MMU_TLB_ASID_EN
    return m_v[i] && (m_vpn[i] == vpn) && ((m_asid[i] == satp[30:22]) || m_fl[i][5]);
`else
    return m_v[i] && (m_vpn[i] == vpn);
`endif
  endfunction

  task automatic model_lookup(input logic [31:0] va, input logic [31:0] pte, input logic pflt,
                              output logic e_walk);
    int          h;
    int          slot;
    logic        e_flt;
    logic [31:0] e_pa;
    logic [9:0]  e_fl;
    h = -1; e_walk = 1'b0; e_flt = 1'b0; e_pa = va; e_fl = '0;
    if (satp[31]) begin
      for (int i = 0; i < ENTRIES; i++) if (h < 0 && m_match(i, va[31:12])) h = i;
      if (h >= 0) begin
        e_pa = {m_ppn[h], va[11:0]};
        e_fl = m_fl[h];
      end else begin
        e_walk = 1'b1;
        if (pflt) begin
          e_flt = 1'b1;
        end else begin
          e_pa = {pte[29:10], va[11:0]};
          e_fl = pte[9:0];
          slot = m_fills % ENTRIES;
          m_v[slot] = 1'b1; m_vpn[slot] = va[31:12]; m_ppn[slot] = pte[29:10];
          m_fl[slot] = pte[9:0]; m_asid[slot] = satp[30:22];
          m_fills++;
        end
      end
    end
    exp_q.push_back({e_flt, e_fl, e_pa});
  endtask

  function automatic void apply_satp(input logic [31:0] v);
`ifndef MMU_TLB_ASID_EN
    if (v != satp) m_flush();
`endif
    satp = v;
  endfunction

  task automatic set_satp(input logic [31:0] v);
    @(negedge clk); apply_satp(v);
    @(negedge clk);
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    m_flush();
  endtask

  // Drives one lookup and acts as the PTW if a walk is requested, answering after dly extra cycles.
  task automatic lookup(input logic [31:0] va, input int dly, input logic [31:0] pte, input logic pflt,
                        input logic with_flush, output logic walked, output logic [31:0] req_addr,
                        output logic got, output logic flt, output logic [31:0] pa,
                        output logic [9:0] fl, output int lat);
    walked = 1'b0; req_addr = '0; got = 1'b0; flt = 1'b0; pa = '0; fl = '0; lat = -1;
    @(negedge clk); lookup_valid = 1'b1; lookup_addr = va; flush = with_flush;
    @(negedge clk); lookup_valid = 1'b0; flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!got) begin
        if (resp_valid) begin
          got = 1'b1; flt = resp_fault; pa = resp_paddr; fl = resp_flags; lat = c;
        end else if (ptw_req_valid && !walked) begin
          walked = 1'b1; req_addr = ptw_req_addr;
          @(negedge clk);
          check("ptw_req_one_cycle", {31'b0, ptw_req_valid}, 32'd0);
          repeat (dly) @(negedge clk);
          ptw_update = 1'b1; ptw_vpn = {12'hABC, va[31:12]}; ptw_pte = pte; ptw_fault = pflt;
          @(negedge clk);
          ptw_update = 1'b0; ptw_fault = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic do_txn(input string nm, input logic [31:0] va, input int dly, input logic [31:0] pte,
                        input logic pflt, input logic with_flush, output logic walked,
                        output logic flt, output logic [31:0] pa, output logic [9:0] fl);
    logic        e_walk, got;
    logic [31:0] req_addr;
    logic [42:0] e;
    int          lat;
    if (with_flush) m_flush();
    model_lookup(va, pte, pflt, e_walk);
    lookup(va, dly, pte, pflt, with_flush, walked, req_addr, got, flt, pa, fl, lat);
    e = exp_q.pop_front();
    check({nm, "_resp_seen"}, {31'b0, got}, 32'd1);
    check({nm, "_walk"}, {31'b0, walked}, {31'b0, e_walk});
    if (e_walk) check({nm, "_req_addr"}, req_addr, va);
    else        check({nm, "_latency"}, lat, 32'd0);
    check({nm, "_fault"}, {31'b0, flt}, {31'b0, e[42]});
    if (!e[42]) begin
      check({nm, "_paddr"}, pa, e[31:0]);
      check({nm, "_flags"}, {22'b0, fl}, {22'b0, e[41:32]});
    end
    @(negedge clk);
    check({nm, "_pulse_idle"}, {30'b0, resp_valid, busy}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] va;
    int          dly;
    logic [31:0] pte;
    logic        pflt;
    logic        exp_walk;
    logic        exp_flt;
    logic [31:0] exp_pa;
    logic [9:0]  exp_fl;
  } vec_t;

  vec_t        vecs[8];
  logic        w, f, spurious;
  logic [31:0] pa;
  logic [9:0]  fl;

  initial begin
    vecs[0] = '{32'h0040_1ABC, 2, 32'h0008_00CF, 1'b0, 1'b1, 1'b0, 32'h0020_0ABC, 10'h0CF};
    vecs[1] = '{32'h0040_1123, 0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0020_0123, 10'h0CF};
    vecs[2] = '{32'h0077_7000, 1, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         10'h0};
    vecs[3] = '{32'h0077_7004, 0, 32'h0000_0C0F, 1'b0, 1'b1, 1'b0, 32'h0000_3004, 10'h00F};
    vecs[4] = '{32'h0077_7FFF, 0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_3FFF, 10'h00F};
    vecs[5] = '{32'hFFFF_F000, 3, 32'h3FFF_FC01, 1'b0, 1'b1, 1'b0, 32'hFFFF_F000, 10'h001};
    vecs[6] = '{32'h0000_0FFF, 0, 32'hC000_0C3F, 1'b0, 1'b1, 1'b0, 32'h0000_3FFF, 10'h03F};
    vecs[7] = '{32'hFFFF_F800, 0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hFFFF_F800, 10'h001};
    m_flush();

    // Clock/reset
    repeat (3) @(negedge clk);
    check("reset_outputs", {resp_valid, resp_fault, busy, ptw_req_valid, 28'b0},  32'd0);
    check("reset_paddr", resp_paddr, 32'd0);
    check("reset_flags_reqaddr", {22'b0, resp_flags} | ptw_req_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Bypass with translation off
    do_txn("bypass", 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0, w, f, pa, fl);
    check("bypass_paddr_const", pa, 32'h1234_5678);
    check("bypass_flags_const", {22'b0, fl}, 32'd0);

    set_satp(32'h8000_0000);
    do_flush();
    foreach (vecs[i]) begin
      do_txn($sformatf("vec%0d", i), vecs[i].va, vecs[i].dly, vecs[i].pte, vecs[i].pflt, 1'b0, w, f, pa, fl);
      check($sformatf("vec%0d_walk_const", i), {31'b0, w}, {31'b0, vecs[i].exp_walk});
      check($sformatf("vec%0d_fault_const", i), {31'b0, f}, {31'b0, vecs[i].exp_flt});
      if (!vecs[i].exp_flt) begin
        check($sformatf("vec%0d_paddr_const", i), pa, vecs[i].exp_pa);
        check($sformatf("vec%0d_flags_const", i), {22'b0, fl}, {22'b0, vecs[i].exp_fl});
      end
    end

    // Flush in the same cycle as a lookup of a cached page forces a walk
    do_txn("flush_same_cycle", 32'h0040_1ABC, 0, 32'h0008_00CF, 1'b0, 1'b1, w, f, pa, fl);
    check("flush_same_cycle_walk_const", {31'b0, w}, 32'd1);

    // Flush during WAIT: response still delivered, no fill; a lookup while busy is ignored
    @(negedge clk); lookup_valid = 1'b1; lookup_addr = 32'h00A0_0123;
    @(negedge clk); lookup_valid = 1'b0;
    check("fw_req", {31'b0, ptw_req_valid}, 32'd1);
    check("fw_req_addr", ptw_req_addr, 32'h00A0_0123);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    ptw_update = 1'b1; ptw_vpn = 32'hFFF0_0A00; ptw_pte = 32'h002A_F0DB;
    lookup_valid = 1'b1; lookup_addr = 32'h00B0_0000;
    @(negedge clk); ptw_update = 1'b0; lookup_valid = 1'b0;
    check("fw_resp", {30'b0, resp_valid, resp_fault}, 32'd2);
    check("fw_paddr", resp_paddr, 32'h00AB_C123);
    check("fw_flags", {22'b0, resp_flags}, 32'h0DB);
    m_flush();
    spurious = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || ptw_req_valid) spurious = 1'b1;
    end
    check("busy_lookup_ignored", {31'b0, spurious}, 32'd0);
    do_txn("fw_refetch", 32'h00A0_0123, 1, 32'h002A_F0DB, 1'b0, 1'b0, w, f, pa, fl);
    check("fw_refetch_walk_const", {31'b0, w}, 32'd1);

    // MODE dropped while waiting: silent abort, later PTW update in IDLE is ignored
    @(negedge clk); lookup_valid = 1'b1; lookup_addr = 32'h00C0_0456;
    @(negedge clk); lookup_valid = 1'b0;
    check("abort_req", {31'b0, ptw_req_valid}, 32'd1);
    @(negedge clk); apply_satp(32'h0000_0000);
    @(negedge clk);
    check("abort_idle", {30'b0, busy, resp_valid}, 32'd0);
    ptw_update = 1'b1; ptw_vpn = 32'h0000_0C00; ptw_pte = 32'h0012_30CF;
    @(negedge clk); ptw_update = 1'b0;
    spurious = 1'b0;
    repeat (4) begin
      if (resp_valid || busy) spurious = 1'b1;
      @(negedge clk);
    end
    check("abort_no_resp", {31'b0, spurious}, 32'd0);
    set_satp(32'h8000_0000);
    do_txn("abort_refetch", 32'h00C0_0456, 0, 32'h0012_30CF, 1'b0, 1'b0, w, f, pa, fl);
    check("abort_refetch_walk_const", {31'b0, w}, 32'd1);

    // Fill ENTRIES+1 distinct pages: second survives, first was evicted
    do_flush();
    for (int i = 0; i <= ENTRIES; i++)
      do_txn($sformatf("wrap_fill%0d", i), {20'h10000 + 20'(i), 12'h040}, 0,
             {2'b00, 20'h30000 + 20'(i), 10'h0C7}, 1'b0, 1'b0, w, f, pa, fl);
    do_txn("wrap_second", {20'h10001, 12'h044}, 0, 32'h0, 1'b0, 1'b0, w, f, pa, fl);
    check("wrap_second_hit_const", {31'b0, w}, 32'd0);
    do_txn("wrap_first", {20'h10000, 12'h048}, 0, {2'b00, 20'h30000, 10'h0C7}, 1'b0, 1'b0, w, f, pa, fl);
    check("wrap_first_miss_const", {31'b0, w}, 32'd1);

`ifdef MMU_TLB_ASID_EN
    set_satp(32'h8040_0000);
    do_txn("asid_fill_ng", 32'h00D0_0010, 0, 32'h0040_00CF, 1'b0, 1'b0, w, f, pa, fl);
    do_txn("asid_fill_g", 32'h00E0_0010, 0, 32'h0050_00EF, 1'b0, 1'b0, w, f, pa, fl);
    set_satp(32'h8080_0000);
    do_txn("asid_other_ng", 32'h00D0_0010, 0, 32'h0040_00CF, 1'b0, 1'b0, w, f, pa, fl);
    check("asid_other_ng_miss_const", {31'b0, w}, 32'd1);
    do_txn("asid_other_g", 32'h00E0_0010, 0, 32'h0, 1'b0, 1'b0, w, f, pa, fl);
    check("asid_other_g_hit_const", {31'b0, w}, 32'd0);
`else
    set_satp(32'h8040_0000);
    do_txn("satp_fill", 32'h00D0_0010, 0, 32'h0040_00CF, 1'b0, 1'b0, w, f, pa, fl);
    do_txn("satp_hit", 32'h00D0_0010, 0, 32'h0, 1'b0, 1'b0, w, f, pa, fl);
    check("satp_hit_const", {31'b0, w}, 32'd0);
    set_satp(32'h8080_0000);
    do_txn("satp_changed", 32'h00D0_0010, 0, 32'h0040_00CF, 1'b0, 1'b0, w, f, pa, fl);
    check("satp_changed_miss_const", {31'b0, w}, 32'd1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      int          r;
      logic [19:0] vpn;
      logic [31:0] sel;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_flush();
      end else if (r < 8) begin
        case ($urandom_range(0, 2))
          0:       sel = 32'h8000_0000;
          1:       sel = 32'h8040_0000;
          default: sel = 32'h0000_0000;
        endcase
        set_satp(sel);
      end else begin
        vpn = 20'h00100 + 20'($urandom_range(0, 11));
        do_txn($sformatf("rnd%0d", n), {vpn, 12'($urandom)}, $urandom_range(0, 3),
               {2'b00, vpn ^ 20'hA5A5A, 2'b00, vpn[7:0] | 8'h01}, (vpn[2:0] == 3'd5),
               ($urandom_range(0, 19) == 0), w, f, pa, fl);
      end
      if (n == 75) set_satp(32'h8000_0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
